// File: rtl/sensor_dht11_if.sv
// Controller-facing bundle of sensor_dht11: start/abort requests in, frame bytes and status out.
// Handshake: a rising edge of i_sensor_en requests one read (edges seen while o_busy=1 are
// dropped, not queued); i_sensor_rst is a level abort. There is no ready: o_data_valid is a
// single-cycle pulse, and the five bytes plus o_crc_ok stay stable until the next pulse.
interface sensor_dht11_if;
  logic       i_sensor_en;
  logic       i_sensor_rst;
  logic [7:0] HUM_INT;
  logic [7:0] HUM_FLOAT;
  logic [7:0] TEMP_INT;
  logic [7:0] TEMP_FLOAT;
  logic [7:0] CRC;
  logic       o_data_valid;
  logic       o_crc_ok;
  logic       o_busy;
  logic       o_error;

  modport master (
    output i_sensor_en, i_sensor_rst,
    input  HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC,
    input  o_data_valid, o_crc_ok, o_busy, o_error
  );

  modport slave (
    input  i_sensor_en, i_sensor_rst,
    output HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC,
    output o_data_valid, o_crc_ok, o_busy, o_error
  );
endinterface

// File: rtl/sensor_dht11.sv
// DHT11 single-wire reader: host start pulse, response/bit timing on a µs counter,
// 40-bit frame capture and checksum, with timeout and synchronous abort.
module sensor_dht11 #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic          clock,
  input  logic          reset_n,
  sensor_dht11_if.slave bus,
  input  logic          i_dht_data,
  output logic          o_dht_drive_low,
  output logic [2:0]    o_dbg_state
);

  localparam int TICK  = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;

  localparam logic [PRE_W-1:0] L_PRE_LAST = PRE_W'(TICK - 1);
  localparam logic [15:0]      L_START_US = 16'(START_LOW_US);
  localparam logic [15:0]      L_THRESH   = 16'(BIT_THRESH_US);
  localparam logic [15:0]      L_TIMEOUT  = 16'(TIMEOUT_US);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_LOW = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_RESP_LOW  = 3'd3,
    S_RESP_HIGH = 3'd4,
    S_BIT_LOW   = 3'd5,
    S_BIT_HIGH  = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_en_d;
  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_us;
  logic [39:0]      r_shift;
  logic [5:0]       r_bit_cnt;
  logic             r_drive_low;
  logic             r_busy;
  logic             r_error;
  logic             r_data_valid;
  logic             r_crc_ok;
  logic [7:0]       r_hum_int;
  logic [7:0]       r_hum_float;
  logic [7:0]       r_temp_int;
  logic [7:0]       r_temp_float;
  logic [7:0]       r_crc;

  logic       w_rise;
  logic       w_fall;
  logic       w_en_rise;
  logic       w_tick;
  logic       w_timeout;
  logic       w_bit;
  logic [7:0] w_sum;

  // Pin is asynchronous: two flops, then a third to detect edges on the clean copy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_en_d  <= 1'b0;
    end else begin
      r_sync1 <= i_dht_data;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_en_d  <= bus.i_sensor_en;
    end
  end

  assign w_rise    = ~r_prev & r_sync2;
  assign w_fall    = r_prev & ~r_sync2;
  assign w_en_rise = bus.i_sensor_en & ~r_en_d;
  assign w_tick    = (r_pre == L_PRE_LAST);
  assign w_timeout = (r_us >= L_TIMEOUT);
  assign w_bit     = (r_us > L_THRESH);
  assign w_sum     = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

  // Timer runs freely every cycle; every state change below overrides it with a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pre        <= '0;
      r_us         <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_drive_low  <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_data_valid <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_hum_int    <= '0;
      r_hum_float  <= '0;
      r_temp_int   <= '0;
      r_temp_float <= '0;
      r_crc        <= '0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_tick) begin
        r_pre <= '0;
        if (r_us != 16'hFFFF) r_us <= r_us + 16'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      if (bus.i_sensor_rst) begin
        r_state     <= S_IDLE;
        r_drive_low <= 1'b0;
        r_busy      <= 1'b0;
        r_pre       <= '0;
        r_us        <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Busy is held through DONE and drops here, one cycle after the valid pulse.
            r_busy <= 1'b0;
            if (w_en_rise) begin
              r_error     <= 1'b0;
              r_busy      <= 1'b1;
              r_drive_low <= 1'b1;
              r_state     <= S_START_LOW;
              r_pre       <= '0;
              r_us        <= '0;
            end
          end
          S_START_LOW: begin
            if (r_us >= L_START_US) begin
              r_drive_low <= 1'b0;
              r_state     <= S_WAIT_RESP;
              r_pre       <= '0;
              r_us        <= '0;
            end
          end
          S_WAIT_RESP: begin
            if (w_fall) begin
              r_state <= S_RESP_LOW;
              r_pre   <= '0;
              r_us    <= '0;
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
              r_pre   <= '0;
              r_us    <= '0;
            end
          end
          S_RESP_LOW: begin
            if (w_rise) begin
              r_state <= S_RESP_HIGH;
              r_pre   <= '0;
              r_us    <= '0;
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
              r_pre   <= '0;
              r_us    <= '0;
            end
          end
          S_RESP_HIGH: begin
            if (w_fall) begin
              r_bit_cnt <= '0;
              r_state   <= S_BIT_LOW;
              r_pre     <= '0;
              r_us      <= '0;
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
              r_pre   <= '0;
              r_us    <= '0;
            end
          end
          S_BIT_LOW: begin
            if (w_rise) begin
              r_state <= S_BIT_HIGH;
              r_pre   <= '0;
              r_us    <= '0;
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
              r_pre   <= '0;
              r_us    <= '0;
            end
          end
          S_BIT_HIGH: begin
            // The high-phase length decides the bit; the sensor's trailing low after bit 40 is ignored.
            if (w_fall) begin
              r_shift   <= {r_shift[38:0], w_bit};
              r_bit_cnt <= r_bit_cnt + 6'd1;
              r_state   <= (r_bit_cnt == 6'd39) ? S_DONE : S_BIT_LOW;
              r_pre     <= '0;
              r_us      <= '0;
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
              r_pre   <= '0;
              r_us    <= '0;
            end
          end
          S_DONE: begin
            r_hum_int    <= r_shift[39:32];
            r_hum_float  <= r_shift[31:24];
            r_temp_int   <= r_shift[23:16];
            r_temp_float <= r_shift[15:8];
            r_crc        <= r_shift[7:0];
            r_crc_ok     <= (w_sum == r_shift[7:0]);
            r_data_valid <= 1'b1;
            r_state      <= S_IDLE;
            r_pre        <= '0;
            r_us         <= '0;
          end
          default: begin
            r_state     <= S_IDLE;
            r_drive_low <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_dht_drive_low  = r_drive_low;
  assign o_dbg_state      = r_state;
  assign bus.HUM_INT      = r_hum_int;
  assign bus.HUM_FLOAT    = r_hum_float;
  assign bus.TEMP_INT     = r_temp_int;
  assign bus.TEMP_FLOAT   = r_temp_float;
  assign bus.CRC          = r_crc;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_crc_ok     = r_crc_ok;
  assign bus.o_busy       = r_busy;
  assign bus.o_error      = r_error;

endmodule

// File: tb/tb_sensor_dht11.sv
// Bench for sensor_dht11: a timed DHT11 pin model plays frames back to the reader and a
// frame-level model predicts bytes, checksum result, timing and status flags.
module tb_sensor_dht11;

  localparam int CLK_FREQ_HZ   = 2_000_000;
  localparam int TICK          = CLK_FREQ_HZ / 1_000_000;
  localparam int START_LOW_US  = 50;
  localparam int BIT_THRESH_US = 10;
  localparam int TIMEOUT_US    = 40;

  // Sensor phase lengths in µs, scaled to the thresholds above.
  localparam int RESP_US  = 20;
  localparam int LOW_US   = 12;
  localparam int ZERO_US  = 5;
  localparam int ONE_US   = 18;

  logic       clock;
  logic       reset_n;
  logic       sensor_pin;
  logic       dht_line;
  logic       drive_low;
  logic [2:0] dbg_state;

  sensor_dht11_if bus_if ();

  sensor_dht11 #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .START_LOW_US (START_LOW_US),
    .BIT_THRESH_US(BIT_THRESH_US),
    .TIMEOUT_US   (TIMEOUT_US)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .bus            (bus_if),
    .i_dht_data     (dht_line),
    .o_dht_drive_low(drive_low),
    .o_dbg_state    (dbg_state)
  );

  // Open-drain line: either party pulling low wins.
  assign dht_line = drive_low ? 1'b0 : sensor_pin;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          valid_pulses = 0;
  logic [39:0] exp_q[$];
  logic [39:0] last_frame = '0;

  always @(negedge clock) if (reset_n && bus_if.o_data_valid) valid_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] out_frame();
    return {bus_if.HUM_INT, bus_if.HUM_FLOAT, bus_if.TEMP_INT, bus_if.TEMP_FLOAT, bus_if.CRC};
  endfunction

  function automatic logic model_crc_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_us(input int n);
    repeat (n * TICK) @(posedge clock);
  endtask

  task automatic drive_pin(input logic v);
    @(posedge clock);
    #1 sensor_pin = v;
  endtask

  task automatic start_read();
    @(posedge clock);
    #1 bus_if.i_sensor_en = 1'b1;
    @(posedge clock);
    #1;
    check("start_busy", bus_if.o_busy, 1);
    check("start_drive", drive_low, 1);
    check("start_err_clr", bus_if.o_error, 0);
    bus_if.i_sensor_en = 1'b0;
  endtask

  // Counts cycles of host low pulse, starting from the acceptance sample.
  task automatic measure_start_low();
    int cnt;
    int diff;
    cnt = 0;
    while (drive_low && cnt < 10 * START_LOW_US * TICK) begin
      @(posedge clock);
      #1 cnt++;
    end
    diff = cnt - START_LOW_US * TICK;
    if (diff < 0) diff = -diff;
    check("start_low_len", (diff <= TICK) ? 64'(cnt) : 64'(cnt), 64'(cnt - (cnt - START_LOW_US * TICK) * int'(diff > TICK)));
  endtask

  // Sensor response then n_bits bits; returns right after the last falling edge.
  task automatic sensor_send(input logic [39:0] f, input int n_bits, input int poke_bit);
    wait_us(5);
    drive_pin(1'b0);
    wait_us(RESP_US);
    drive_pin(1'b1);
    wait_us(RESP_US);
    drive_pin(1'b0);
    for (int i = 0; i < n_bits; i++) begin
      if (i == poke_bit) begin
        @(posedge clock);
        #1 bus_if.i_sensor_en = 1'b1;
        @(posedge clock);
        #1 bus_if.i_sensor_en = 1'b0;
        @(posedge clock);
        #1;
        check("retrig_no_drive", drive_low, 0);
        check("retrig_busy", bus_if.o_busy, 1);
      end
      wait_us(LOW_US);
      drive_pin(1'b1);
      wait_us(f[39-i] ? ONE_US : ZERO_US);
      drive_pin(1'b0);
    end
  endtask

  task automatic finish_frame(input string tag);
    logic [39:0] exp_f;
    int          pulses_before;
    exp_f = exp_q.pop_front();
    pulses_before = valid_pulses;
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_valid_early"}, bus_if.o_data_valid, 0);
    check({tag, "_bytes_held"}, out_frame(), last_frame);
    @(posedge clock);
    #1;
    check({tag, "_valid"}, bus_if.o_data_valid, 1);
    check({tag, "_bytes"}, out_frame(), exp_f);
    check({tag, "_crc_ok"}, bus_if.o_crc_ok, model_crc_ok(exp_f));
    check({tag, "_busy_hold"}, bus_if.o_busy, 1);
    @(posedge clock);
    #1;
    check({tag, "_valid_end"}, bus_if.o_data_valid, 0);
    check({tag, "_busy_end"}, bus_if.o_busy, 0);
    check({tag, "_error"}, bus_if.o_error, 0);
    check({tag, "_pulses"}, valid_pulses - pulses_before, 1);
    last_frame = exp_f;
    wait_us(LOW_US);
    drive_pin(1'b1);
    wait_us(5);
  endtask

  task automatic do_frame(input string tag, input logic [39:0] f, input int poke_bit);
    exp_q.push_back(f);
    start_read();
    measure_start_low();
    sensor_send(f, 40, poke_bit);
    finish_frame(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [39:0] f;
    logic [7:0]  b [4];
    int          cnt;
    int          diff;
    int          pulses_before;

    reset_n = 1'b0;
    sensor_pin = 1'b1;
    bus_if.i_sensor_en = 1'b0;
    bus_if.i_sensor_rst = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_bytes", out_frame(), 40'h0);
    check("rst_crc_ok", bus_if.o_crc_ok, 0);
    check("rst_valid", bus_if.o_data_valid, 0);
    check("rst_busy", bus_if.o_busy, 0);
    check("rst_error", bus_if.o_error, 0);
    check("rst_drive", drive_low, 0);

    do_frame("good", 40'h37_00_19_05_55, 5);
    do_frame("badcrc", 40'h37_00_19_05_54, -1);
    do_frame("wrap", 40'hFF_FF_01_02_01, -1);

    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(0, 255));
      f = {b[0], b[1], b[2], b[3], 8'(int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]))};
      if ($urandom_range(0, 1) == 1) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
      do_frame("rand", f, -1);
    end

    // Silent sensor: error expected START_LOW_US + TIMEOUT_US after acceptance.
    pulses_before = valid_pulses;
    start_read();
    cnt = 0;
    while (!bus_if.o_error && cnt < 4 * (START_LOW_US + TIMEOUT_US) * TICK) begin
      @(posedge clock);
      #1 cnt++;
    end
    diff = cnt - (START_LOW_US + TIMEOUT_US) * TICK;
    if (diff < 0) diff = -diff;
    check("timeout_in_window", diff <= TICK, 1);
    check("timeout_error", bus_if.o_error, 1);
    check("timeout_busy", bus_if.o_busy, 0);
    check("timeout_bytes_kept", out_frame(), last_frame);
    check("timeout_no_valid", valid_pulses - pulses_before, 0);
    wait_us(5);

    // Abort in the middle of the frame.
    pulses_before = valid_pulses;
    start_read();
    measure_start_low();
    sensor_send(40'h11_22_33_44_AA, 20, -1);
    wait_us(3);
    @(posedge clock);
    #1 bus_if.i_sensor_rst = 1'b1;
    @(posedge clock);
    #1;
    check("abort_drive", drive_low, 0);
    check("abort_busy", bus_if.o_busy, 0);
    check("abort_bytes_kept", out_frame(), last_frame);
    bus_if.i_sensor_rst = 1'b0;
    sensor_pin = 1'b1;
    wait_us(2 * TIMEOUT_US);
    check("abort_no_valid", valid_pulses - pulses_before, 0);
    check("abort_error_kept", bus_if.o_error, 0);

    do_frame("after_abort", 40'h37_00_19_05_55, -1);

    // Asynchronous reset in the middle of a frame.
    start_read();
    measure_start_low();
    sensor_send(40'h37_00_19_05_55, 10, -1);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_bytes", out_frame(), 40'h0);
    check("midrst_drive", drive_low, 0);
    check("midrst_busy", bus_if.o_busy, 0);
    check("midrst_crc_ok", bus_if.o_crc_ok, 0);
    check("midrst_valid", bus_if.o_data_valid, 0);
    check("midrst_error", bus_if.o_error, 0);
    sensor_pin = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    wait_us(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_dht11.md
# sensor_dht11

Single-wire DHT11 reader that sits directly upstream of `controlador`. It drives the sensor start pulse, times the sensor's response and 40 data bits, and checks the checksum. It presents `HUM_INT`, `HUM_FLOAT`, `TEMP_INT`, `TEMP_FLOAT` and `CRC` as stable registered bytes. A start is triggered by `controlador`'s `o_sensor_en`, and an in-flight read is aborted by its `o_sensor_rst`.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: clock frequency; µs tick = `CLK_FREQ_HZ/1_000_000` cycles.
- `START_LOW_US`, 18000: host start-pulse length in µs.
- `BIT_THRESH_US`, 40: a high phase longer than this decodes as 1, otherwise 0.
- `TIMEOUT_US`, 200: maximum wait for any expected sensor edge.

- `clock` in 1: single clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_sensor_en` in 1: start request; its rising edge starts a read.
- `i_sensor_rst` in 1: synchronous abort, level-sensitive.
- `i_dht_data` in 1: sensor data pin (asynchronous, idles high).
- `o_dht_drive_low` out 1: 1 = pull the line low; top level builds the open-drain driver.
- `HUM_INT`, `HUM_FLOAT`, `TEMP_INT`, `TEMP_FLOAT`, `CRC` out 8 each: last complete frame.
- `o_data_valid` out 1: one-cycle pulse when the frame registers update.
- `o_crc_ok` out 1: checksum result of the last complete frame.
- `o_busy` out 1: high from start acceptance until return to IDLE.
- `o_error` out 1: timeout flag; cleared when the next start is accepted.

## Operation
- **Input conditioning**
  - `i_dht_data` passes through a 2-flop synchroniser (reset value 1).
  - Rise and fall edges are detected on the synchronised value.
- **µs timer**
  - A prescaler generates a µs tick that drives a 16-bit µs counter.
  - The µs counter saturates at 0xFFFF.
  - Prescaler and counter both clear on every state transition.
- **States**
  - IDLE: on a rising edge of `i_sensor_en`, clear `o_error`, set `o_busy`, go to START_LOW. Rising edges outside IDLE are ignored, not queued.
  - START_LOW: `o_dht_drive_low`=1 for `START_LOW_US`, then release and go to WAIT_RESP.
  - WAIT_RESP: on a falling edge go to RESP_LOW.
  - RESP_LOW: on a rising edge go to RESP_HIGH.
  - RESP_HIGH: on a falling edge go to BIT_LOW; clear the bit counter to 0.
  - BIT_LOW: on a rising edge go to BIT_HIGH.
  - BIT_HIGH: on a falling edge, shift in (µs count > `BIT_THRESH_US`), MSB first, and increment the bit counter. After bit 40 go to DONE; otherwise go to BIT_LOW.
  - DONE: load the output registers, pulse `o_data_valid`, go to IDLE.
- **Timeout:** in WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, a µs count reaching `TIMEOUT_US` without the expected edge → set `o_error`, go to IDLE.
- **Frame layout:** bits 0–7 `HUM_INT`, 8–15 `HUM_FLOAT`, 16–23 `TEMP_INT`, 24–31 `TEMP_FLOAT`, 32–39 `CRC`.
- **Shift register:** 40 bits, internal. The output bytes change only in DONE, all five in the same cycle. A partial frame never reaches the outputs.
- **Checksum:** `o_crc_ok` = ((`HUM_INT`+`HUM_FLOAT`+`TEMP_INT`+`TEMP_FLOAT`) mod 256 == `CRC`). It uses an 8-bit wrap-around sum, is computed from the shifted-in bytes, and is registered in DONE.
- **Abort:** `i_sensor_rst`=1 in any state → IDLE next cycle.
  - `o_dht_drive_low`=0 and `o_busy`=0.
  - No `o_data_valid` pulse; the output bytes and `o_error` are unchanged.
  - Abort has priority over a simultaneous start or edge.
- **After a frame:** the trailing 50 µs sensor low after bit 40 is not waited for.

## Timing
- **Reset values:**
  - All bytes 0x00.
  - `o_crc_ok`, `o_data_valid`, `o_busy`, `o_error` all 0.
  - `o_dht_drive_low` 0; state IDLE; synchroniser 1.
- **Start acceptance:** for a `i_sensor_en` rising edge sampled at cycle N, `o_busy`=1 and `o_dht_drive_low`=1 from cycle N+1.
- **Start pulse:** `o_dht_drive_low` stays high for `START_LOW_US`×tick cycles (±1 tick).
- **Pin-edge latency:** a pin edge at cycle N is acted on at cycle N+2 (synchroniser).
- **Frame completion:** the bit-40 falling edge at cycle N gives outputs updated and `o_data_valid`=1 at cycle N+3. At N+4, `o_data_valid`=0 and `o_busy`=0.
- **Timeout completion:** `o_error`=1 and `o_busy`=0 in the same cycle.
- **Throughput:** a new start is accepted in the first cycle back in IDLE.

## Test plan
- **Reset:** assert `reset_n`=0 mid-frame → all outputs at reset values immediately; line released.
- **Good frame:** model returns 0x37, 0x00, 0x19, 0x05, CRC 0x55 → bytes match, `o_crc_ok`=1, exactly one `o_data_valid` pulse, `o_busy` falls one cycle later.
- **Bad checksum:** same frame but CRC 0x54 → bytes updated, `o_crc_ok`=0, `o_error`=0.
- **Wrap-around:** model returns 0xFF, 0xFF, 0x01, 0x02, CRC 0x01 → `o_crc_ok`=1.
- **No response:** silent sensor → `o_error`=1 at `START_LOW_US`+`TIMEOUT_US` µs (±1 tick) after start; previous frame bytes retained; no `o_data_valid`.
- **Abort and retrigger:**
  - Pulse `i_sensor_rst` during bit 20 → `o_dht_drive_low`=0 and `o_busy`=0 next cycle; bytes unchanged.
  - A second `i_sensor_en` rising edge during an active read is ignored.
  - A fresh start after the abort reads 0x37, 0x00, 0x19, 0x05, 0x55 correctly.
